// File: rtl/handshake_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin handshake arbiter.
package handshake_arb_pkg;

    localparam int unsigned NUM_REQ_DEF   = 3;
    localparam int unsigned DATA_W_DEF    = 5;
    localparam int unsigned MAX_BURST_DEF = 2;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

    // One downstream beat at the default configuration: source index plus payload.
    typedef struct packed {
        req_idx_t                src;
        logic [DATA_W_DEF-1:0]   data;
    } beat_t;

    // Lock state of the arbiter: free round-robin or holding a burst owner.
    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Increment an index modulo n.
    function automatic int unsigned next_idx(input int unsigned i, input int unsigned n);
        return ((i + 32'd1) >= n) ? 32'd0 : (i + 32'd1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority search: first set request at or after start.
module rr_priority_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W:0] off;
    logic [IDX_W:0] sum;

    // Rotate so that bit 0 is the start position, then take the lowest set bit.
    always_comb begin
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        found = 1'b0;
        off   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (rot[IDX_W'(k)]) begin
                found = 1'b1;
                off   = (IDX_W+1)'(k);
            end
        end
        sum = {1'b0, start} + off;
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter with bounded burst lock feeding one registered ready/valid stage.
module handshake_rr_arbiter
    import handshake_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = NUM_REQ_DEF,
    parameter  int unsigned DATA_W    = DATA_W_DEF,
    parameter  int unsigned MAX_BURST = MAX_BURST_DEF,
    localparam int unsigned SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      CLK,
    input  logic                      ASYNCRESETN,
    input  logic [NUM_REQ-1:0]        in_valid,
    output logic [NUM_REQ-1:0]        in_ready,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src
);

    localparam int unsigned     BC_W       = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST);

    arb_state_e        state_q, state_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  owner_q, owner_d;
    logic [BC_W-1:0]   burst_q, burst_d;
    logic [BC_W-1:0]   burst_new;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_data_d;
    logic [SRC_W-1:0]  out_src_d;

    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic              can_load;
    logic              owner_valid;
    logic              lock_hold;
    logic              drop_release;
    logic              pick_found;
    logic              winner_found;
    logic              accept;
    logic [SRC_W-1:0]  pick_start;
    logic [SRC_W-1:0]  pick_idx;
    logic [SRC_W-1:0]  winner;
    logic [SRC_W-1:0]  owner_next;
    logic [SRC_W-1:0]  winner_next;

    // Unpack the flat payload bus into one entry per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = in_data[g*DATA_W +: DATA_W];
    end

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_pick (
        .req   (in_valid),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Winner selection: a valid lock owner keeps the grant, otherwise rotate.
    always_comb begin
        can_load     = !out_valid || out_ready;
        owner_valid  = in_valid[owner_q];
        lock_hold    = (state_q == ARB_LOCKED) && owner_valid;
        drop_release = (state_q == ARB_LOCKED) && !owner_valid;
        owner_next   = SRC_W'(next_idx(32'(owner_q), NUM_REQ));
        // When a lock is dropped, the search restarts just past the old owner.
        pick_start   = (state_q == ARB_LOCKED) ? owner_next : rr_ptr_q;
        winner_found = lock_hold || pick_found;
        winner       = lock_hold ? owner_q : pick_idx;
        winner_next  = SRC_W'(next_idx(32'(winner), NUM_REQ));
        accept       = can_load && winner_found;
        in_ready     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            in_ready[i] = accept && (winner == SRC_W'(i));
        end
    end

    // Next-state: lock/burst bookkeeping and output register load.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_d     = burst_q;
        burst_new   = '0;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_src_d   = out_src;

        if (can_load) begin
            if (drop_release) begin
                state_d  = ARB_FREE;
                rr_ptr_d = owner_next;
                burst_d  = '0;
            end
            if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = data_arr[winner];
                out_src_d   = winner;
                if (lock_hold) begin
                    burst_new = burst_q + 1'b1;
                end else begin
                    burst_new = BC_W'(1);
                    owner_d   = winner;
                end
                if (burst_new == BURST_LAST) begin
                    state_d  = ARB_FREE;
                    burst_d  = '0;
                    rr_ptr_d = winner_next;
                end else begin
                    state_d  = ARB_LOCKED;
                    burst_d  = burst_new;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q   <= ARB_FREE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            burst_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_src   <= out_src_d;
        end
    end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed scoreboard bench for handshake_rr_arbiter (3 requesters, 5-bit data, burst 2).
module tb_handshake_rr_arbiter;
    import handshake_arb_pkg::*;

    localparam int unsigned NUM_REQ   = 3;
    localparam int unsigned DATA_W    = 5;
    localparam int unsigned MAX_BURST = 2;

    logic                      CLK;
    logic                      ASYNCRESETN;
    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ-1:0]        in_ready;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [1:0]                out_src;

    beat_t exp_q[$];
    beat_t exp_b;
    int    n_vec;
    int    n_err;

    handshake_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_src     (out_src)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int s, input int d);
        beat_t b;
        b.src  = req_idx_t'(s);
        b.data = DATA_W'(d);
        return b;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic [2:0] v, input logic [4:0] d0,
                          input logic [4:0] d1, input logic [4:0] d2);
        in_valid = v;
        in_data  = {d2, d1, d0};
    endtask

    task automatic do_reset();
        ASYNCRESETN = 1'b0;
        in_valid    = '0;
        out_ready   = 1'b0;
        step();
        step();
        ASYNCRESETN = 1'b1;
    endtask

    // Wait (bounded) until every expected beat has been consumed.
    task automatic drain(input string name);
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every beat taken downstream is popped and compared.
    always @(negedge CLK) begin
        if (ASYNCRESETN && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got src=%0d data=0x%0h, expected no beat",
                         out_src, out_data);
            end else begin
                exp_b = exp_q.pop_front();
                check("beat_src", 32'(out_src), 32'(exp_b.src));
                check("beat_data", 32'(out_data), 32'(exp_b.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        ASYNCRESETN = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = 1'b0;

        // 1. reset values, first grant, asynchronous reset with a held beat
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_src", 32'(out_src), 32'd0);
        ASYNCRESETN = 1'b1;
        set_in(3'b111, 5'h01, 5'h02, 5'h03);
        #1;
        check("first_grant", 32'(in_ready), 32'h1);
        step();
        check("held_valid", 32'(out_valid), 32'd1);
        check("held_src", 32'(out_src), 32'd0);
        check("held_data", 32'(out_data), 32'h01);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_data", 32'(out_data), 32'd0);
        check("async_src", 32'(out_src), 32'd0);
        do_reset();

        // 2. all valid: bursts of two, wrap back to requester 0
        out_ready = 1'b1;
        set_in(3'b111, 5'h01, 5'h02, 5'h03);
        exp_q.push_back(mk(0, 1)); exp_q.push_back(mk(0, 1));
        exp_q.push_back(mk(1, 2)); exp_q.push_back(mk(1, 2));
        exp_q.push_back(mk(2, 3)); exp_q.push_back(mk(2, 3));
        exp_q.push_back(mk(0, 1));
        repeat (7) step();
        set_in(3'b000, 5'h01, 5'h02, 5'h03);
        drain("drain_all_valid");
        do_reset();

        // 3. lone requester 2 re-granted every cycle
        out_ready = 1'b1;
        set_in(3'b100, 5'h00, 5'h00, 5'h1F);
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(2, 'h1F));
        for (int i = 0; i < 4; i++) begin
            #1;
            check("solo_ready", 32'(in_ready), 32'h4);
            step();
            check("solo_valid", 32'(out_valid), 32'd1);
        end
        set_in(3'b000, 5'h00, 5'h00, 5'h1F);
        drain("drain_solo");
        do_reset();

        // 4. downstream stall after beat src=1 data=0x0A
        out_ready = 1'b1;
        set_in(3'b111, 5'h04, 5'h0A, 5'h0C);
        exp_q.push_back(mk(0, 'h04)); exp_q.push_back(mk(0, 'h04));
        exp_q.push_back(mk(1, 'h0A)); exp_q.push_back(mk(1, 'h0A));
        exp_q.push_back(mk(2, 'h0C)); exp_q.push_back(mk(2, 'h0C));
        repeat (3) step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_ready", 32'(in_ready), 32'h0);
            check("stall_data", 32'(out_data), 32'h0A);
            check("stall_src", 32'(out_src), 32'd1);
            step();
        end
        out_ready = 1'b1;
        repeat (3) step();
        set_in(3'b000, 5'h04, 5'h0A, 5'h0C);
        drain("drain_stall");
        do_reset();

        // 5. lock owner drops: requester 1 wins in the same cycle
        out_ready = 1'b1;
        set_in(3'b001, 5'h07, 5'h11, 5'h13);
        exp_q.push_back(mk(0, 'h07));
        exp_q.push_back(mk(1, 'h11)); exp_q.push_back(mk(1, 'h11));
        exp_q.push_back(mk(2, 'h13)); exp_q.push_back(mk(2, 'h13));
        exp_q.push_back(mk(0, 'h07));
        step();
        set_in(3'b010, 5'h07, 5'h11, 5'h13);
        #1;
        check("drop_ready", 32'(in_ready), 32'h2);
        step();
        set_in(3'b111, 5'h07, 5'h11, 5'h13);
        repeat (4) step();
        set_in(3'b000, 5'h07, 5'h11, 5'h13);
        drain("drain_drop");
        do_reset();

        // 6. accept while the held beat drains: no bubble
        out_ready = 1'b1;
        set_in(3'b010, 5'h00, 5'h05, 5'h00);
        exp_q.push_back(mk(1, 'h05));
        exp_q.push_back(mk(1, 'h15));
        step();
        check("pass_valid1", 32'(out_valid), 32'd1);
        check("pass_ready", 32'(in_ready), 32'h2);
        set_in(3'b010, 5'h00, 5'h15, 5'h00);
        step();
        check("pass_valid2", 32'(out_valid), 32'd1);
        check("pass_data2", 32'(out_data), 32'h15);
        set_in(3'b000, 5'h00, 5'h15, 5'h00);
        step();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_data", 32'(out_data), 32'h15);
        check("idle_src", 32'(out_src), 32'd1);
        drain("drain_pass");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
